// File: rtl/byte_stuffing.sv
// Transmit-side HDLC/PPP byte stuffer: escapes flag/escape (and optionally
// control) bytes into ESC_BYTE, byte ^ XOR_MASK pairs on a valid/ready stream.
module byte_stuffing #(
  parameter logic [7:0] FLAG_BYTE   = 8'h7E,
  parameter logic [7:0] ESC_BYTE    = 8'h7D,
  parameter logic [7:0] XOR_MASK    = 8'h20,
  parameter bit         ESCAPE_CTRL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sop_in,
  input  logic       eop_in,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_in,
  output logic       sop_stf,
  output logic       eop_stf,
  output logic [7:0] data_stf,
  output logic       valid_stf,
  input  logic       ready_stf,
  output logic [7:0] stuff_cnt,
  output logic       err_frame
);

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
  localparam logic [1:0] ESC2 = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [DW-1:0] data_nxt, esc_data, esc_data_nxt;
  logic          sop_nxt, eop_nxt, valid_nxt;
  logic          esc_eop, esc_eop_nxt;
  logic [CW-1:0] cnt_nxt, cnt_base;
  logic          err_nxt;
  logic          accept_c;
  logic          need_esc_c;

  // Upstream may push whenever no second escape byte is pending and the output slot frees
  assign ready_in   = rst & (state != ESC2) & (~valid_stf | ready_stf);
  assign accept_c   = valid_in & ready_in;
  assign need_esc_c = (data_in == FLAG_BYTE) | (data_in == ESC_BYTE) |
                      (ESCAPE_CTRL & (data_in < 8'h20));

  // Next-state and output-stage load decisions
  always_comb begin
    state_nxt    = state;
    data_nxt     = data_stf;
    sop_nxt      = sop_stf;
    eop_nxt      = eop_stf;
    valid_nxt    = valid_stf & ~ready_stf;
    esc_data_nxt = esc_data;
    esc_eop_nxt  = esc_eop;
    cnt_nxt      = stuff_cnt;
    cnt_base     = stuff_cnt;
    err_nxt      = 1'b0;
    case (state)
      IDLE, DATA: begin
        if (accept_c) begin
          if (!sop_in && (state == IDLE)) begin
            // stray byte outside a frame is dropped
            err_nxt = 1'b1;
          end else begin
            // sop inside an open frame abandons the old frame
            if (sop_in && (state == DATA)) err_nxt = 1'b1;
            if (sop_in) cnt_base = '0;
            cnt_nxt   = cnt_base;
            valid_nxt = 1'b1;
            sop_nxt   = sop_in;
            if (need_esc_c) begin
              data_nxt     = ESC_BYTE;
              eop_nxt      = 1'b0;
              esc_data_nxt = data_in ^ XOR_MASK;
              esc_eop_nxt  = eop_in;
              cnt_nxt      = (cnt_base == 8'hFF) ? cnt_base : cnt_base + CW'(1);
              state_nxt    = ESC2;
            end else begin
              data_nxt  = data_in;
              eop_nxt   = eop_in;
              state_nxt = eop_in ? IDLE : DATA;
            end
          end
        end
      end
      ESC2: begin
        if (!valid_stf || ready_stf) begin
          valid_nxt = 1'b1;
          data_nxt  = esc_data;
          sop_nxt   = 1'b0;
          eop_nxt   = esc_eop;
          state_nxt = esc_eop ? IDLE : DATA;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, output stage and counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      data_stf  <= '0;
      sop_stf   <= 1'b0;
      eop_stf   <= 1'b0;
      valid_stf <= 1'b0;
      esc_data  <= '0;
      esc_eop   <= 1'b0;
      stuff_cnt <= '0;
      err_frame <= 1'b0;
    end else begin
      state     <= state_nxt;
      data_stf  <= data_nxt;
      sop_stf   <= sop_nxt;
      eop_stf   <= eop_nxt;
      valid_stf <= valid_nxt;
      esc_data  <= esc_data_nxt;
      esc_eop   <= esc_eop_nxt;
      stuff_cnt <= cnt_nxt;
      err_frame <= err_nxt;
    end
  end

endmodule

// File: tb/tb_byte_stuffing.sv
// Self-checking bench for byte_stuffing: directed and random frames on two
// instances (control-byte escaping off/on) against a queue-based reference.
module tb_byte_stuffing;

  logic       clk = 1'b0;
  logic       rst;
  logic       sop_in, eop_in, valid_in, ready_stf;
  logic [7:0] data_in;
  int         sel;

  logic       ri0, ss0, es0, vs0, ef0;
  logic [7:0] ds0, sc0;
  logic       ri1, ss1, es1, vs1, ef1;
  logic [7:0] ds1, sc1;
  logic       vin0, vin1;

  logic       ready_m, sop_m, eop_m, valid_m, err_m;
  logic [7:0] data_m, cnt_m;

  always #5 clk = ~clk;

  assign vin0 = valid_in & (sel == 0);
  assign vin1 = valid_in & (sel == 1);

  assign ready_m = (sel == 1) ? ri1 : ri0;
  assign sop_m   = (sel == 1) ? ss1 : ss0;
  assign eop_m   = (sel == 1) ? es1 : es0;
  assign valid_m = (sel == 1) ? vs1 : vs0;
  assign err_m   = (sel == 1) ? ef1 : ef0;
  assign data_m  = (sel == 1) ? ds1 : ds0;
  assign cnt_m   = (sel == 1) ? sc1 : sc0;

  byte_stuffing #(.ESCAPE_CTRL(1'b0)) dut0 (
    .clk(clk), .rst(rst), .sop_in(sop_in), .eop_in(eop_in), .data_in(data_in),
    .valid_in(vin0), .ready_in(ri0), .sop_stf(ss0), .eop_stf(es0),
    .data_stf(ds0), .valid_stf(vs0), .ready_stf(ready_stf),
    .stuff_cnt(sc0), .err_frame(ef0));

  byte_stuffing #(.ESCAPE_CTRL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .sop_in(sop_in), .eop_in(eop_in), .data_in(data_in),
    .valid_in(vin1), .ready_in(ri1), .sop_stf(ss1), .eop_stf(es1),
    .data_stf(ds1), .valid_stf(vs1), .ready_stf(ready_stf),
    .stuff_cnt(sc1), .err_frame(ef1));

  int n_cmp = 0;
  int n_bad = 0;

  // beat = {sop, eop, data}
  logic [9:0] exp_q[$];
  logic [9:0] obs_q[$];
  int         exp_err, err_seen, rdy_low;
  bit         m_in_frame[2];
  int         m_cnt[2];
  bit         hold_prev;
  logic [9:0] held;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: what the escaped stream of one accepted byte must be
  task automatic model_byte(input logic [7:0] d, input bit sop, input bit eop);
    bit esc;
    if (!m_in_frame[sel] && !sop) begin
      exp_err++;
      return;
    end
    if (m_in_frame[sel] && sop) exp_err++;
    if (sop) m_cnt[sel] = 0;
    m_in_frame[sel] = 1'b1;
    esc = (d == 8'h7E) || (d == 8'h7D) || ((sel == 1) && (d < 8'h20));
    if (esc) begin
      exp_q.push_back({sop, 1'b0, 8'h7D});
      exp_q.push_back({1'b0, eop, d ^ 8'h20});
      if (m_cnt[sel] < 255) m_cnt[sel]++;
    end else begin
      exp_q.push_back({sop, eop, d});
    end
    if (eop) m_in_frame[sel] = 1'b0;
  endtask

  // One clock cycle from a falling edge; mode 0: ready=1, 1: random, 2: ready=0
  task automatic tick(input int mode, output bit acc);
    ready_stf = (mode == 0) ? 1'b1 : (mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
    #1;
    if (hold_prev) chk("hold_stable", 32'({sop_m, eop_m, data_m}), 32'(held));
    if (valid_m && ready_stf) obs_q.push_back({sop_m, eop_m, data_m});
    if (err_m) err_seen++;
    if (valid_in && !ready_m) rdy_low++;
    acc = valid_in && ready_m;
    hold_prev = valid_m && !ready_stf;
    held = {sop_m, eop_m, data_m};
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input bit sop, input bit eop, input int mode);
    bit acc;
    int n;
    data_in = d; sop_in = sop; eop_in = eop; valid_in = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 100) begin
      tick(mode, acc);
      n++;
    end
    if (!acc) chk("accept_timeout", 32'(n), 32'(0));
    else model_byte(d, sop, eop);
  endtask

  task automatic drain(input int cycles);
    bit acc;
    valid_in = 1'b0; sop_in = 1'b0; eop_in = 1'b0;
    repeat (cycles) tick(0, acc);
  endtask

  task automatic start_case(input int which);
    sel = which;
    exp_q.delete();
    obs_q.delete();
    exp_err = 0;
    err_seen = 0;
    rdy_low = 0;
  endtask

  task automatic verify(input string tag);
    int n;
    drain(12);
    chk({tag, "_len"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_beat"}, 32'(obs_q[i]), 32'(exp_q[i]));
    chk({tag, "_err"}, 32'(err_seen), 32'(exp_err));
    chk({tag, "_cnt"}, 32'(cnt_m), 32'(m_cnt[sel]));
  endtask

  initial begin
    bit acc;
    int len;
    logic [7:0] b;
    rst = 1'b0; sel = 0; valid_in = 1'b0; sop_in = 1'b0; eop_in = 1'b0;
    data_in = '0; ready_stf = 1'b1; hold_prev = 1'b0; held = '0;
    m_in_frame[0] = 0; m_in_frame[1] = 0; m_cnt[0] = 0; m_cnt[1] = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 32'(valid_m), 32'(0));
    chk("rst_ready_low", 32'(ready_m), 32'(0));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_ready", 32'(ready_m), 32'(1));
    chk("rst_out", 32'({sop_m, eop_m, data_m, err_m}), 32'(0));
    chk("rst_cnt", 32'(cnt_m), 32'(0));
    @(negedge clk);

    // plain frame, latency 1, ready_in never drops
    start_case(0);
    send(8'h01, 1, 0, 0);
    chk("latency1", 32'({valid_m, data_m}), 32'({1'b1, 8'h01}));
    send(8'h02, 0, 0, 0);
    send(8'h03, 0, 1, 0);
    verify("noesc");
    chk("noesc_rdy_low", 32'(rdy_low), 32'(0));

    // both specials, one stall cycle each
    start_case(0);
    send(8'h11, 1, 0, 0);
    send(8'h7E, 0, 0, 0);
    send(8'h7D, 0, 0, 0);
    send(8'h22, 0, 1, 0);
    verify("specials");
    chk("specials_rdy_low", 32'(rdy_low), 32'(2));

    // single-byte escaped frame, then frame ending in escape byte
    start_case(0);
    send(8'h7E, 1, 1, 0);
    verify("single7e");
    start_case(0);
    send(8'h05, 1, 0, 0);
    send(8'h7D, 0, 1, 0);
    verify("end7d");

    // backpressure on the escape byte
    start_case(0);
    send(8'h7E, 1, 0, 0);
    data_in = 8'h33; sop_in = 1'b0; eop_in = 1'b1; valid_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(2, acc);
      chk("bp_data", 32'({valid_m, data_m}), 32'({1'b1, 8'h7D}));
      chk("bp_ready_in", 32'(ready_m), 32'(0));
    end
    send(8'h33, 0, 1, 0);
    verify("backpressure");

    // control-byte escaping on and off
    start_case(1);
    send(8'h05, 1, 0, 0);
    send(8'h41, 0, 1, 0);
    verify("ctrl_on");
    start_case(0);
    send(8'h05, 1, 0, 0);
    send(8'h41, 0, 1, 0);
    verify("ctrl_off");

    // framing errors
    start_case(0);
    send(8'h55, 0, 0, 0);
    verify("stray");
    start_case(0);
    send(8'h01, 1, 0, 0);
    send(8'h7E, 0, 0, 0);
    send(8'h03, 1, 0, 0);
    send(8'h04, 0, 1, 0);
    verify("sop_mid");

    // counter saturation
    start_case(0);
    for (int i = 0; i < 260; i++) send(8'h7E, i == 0, i == 259, 0);
    verify("saturate");

    // random frames with random backpressure on both instances
    for (int inst = 0; inst < 2; inst++) begin
      for (int f = 0; f < 8; f++) begin
        start_case(inst);
        len = $urandom_range(1, 8);
        for (int i = 0; i < len; i++) begin
          case ($urandom_range(0, 3))
            0: b = 8'h7E;
            1: b = 8'h7D;
            2: b = 8'($urandom_range(0, 31));
            default: b = 8'($urandom);
          endcase
          send(b, i == 0, i == len - 1, 1);
        end
        verify("random");
      end
    end

    // reset while the second escape byte is pending
    start_case(0);
    data_in = 8'h7E; sop_in = 1'b1; eop_in = 1'b0; valid_in = 1'b1;
    tick(0, acc);
    chk("pre_rst_accept", 32'(acc), 32'(1));
    valid_in = 1'b0;
    rst = 1'b0;
    #1;
    chk("midrst_valid", 32'(valid_m), 32'(0));
    chk("midrst_cnt", 32'(cnt_m), 32'(0));
    @(negedge clk);
    rst = 1'b1;
    m_in_frame[0] = 0; m_cnt[0] = 0;
    hold_prev = 1'b0;
    obs_q.delete();
    verify("midrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
